i2s_tx: RTL and testbench

- Downstream neighbour of the volume-scaling stage. Consumes one scaled 16-bit signed stereo sample pair per audio frame and serializes it onto a standard Philips I2S bus (BCLK, LRCLK, SDATA) toward the external codec.
- Generates the bit and word clocks from the system clock with a programmable divider.
- Holds one pair in a single-entry buffer and flags underruns.

---
 rtl/i2s_tx_if.sv | 12 +
 rtl/i2s_tx.sv | 82 ++++++++
 tb/tb_i2s_tx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample-pair stream from the volume stage into the I2S transmitter.
interface i2s_tx_if #(
  parameter int SAMPLE_BITS = 16
);
  logic signed [SAMPLE_BITS-1:0] left_in;
  logic signed [SAMPLE_BITS-1:0] right_in;
  logic                          sample_valid;
  logic                          sample_ready;

  modport master (output left_in, output right_in, output sample_valid, input sample_ready);
  modport slave  (input left_in, input right_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: divides clk into BCLK/LRCLK and serializes one
// buffered signed stereo pair per 32-BCLK frame, flagging underruns.
module i2s_tx #(
  parameter int CLK_DIV     = 32,
  parameter int SAMPLE_BITS = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  i2s_tx_if.slave  s_if,
  output logic     bclk,
  output logic     lrclk,
  output logic     sdata,
  output logic     underrun
);
  localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME_W = 2 * SAMPLE_BITS;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]              div_cnt_q, div_cnt_d;
  logic                          bclk_q, bclk_d;
  logic [4:0]                    slot_q, slot_d;
  logic [FRAME_W-1:0]            shift_q, shift_d;
  logic                          full_q, full_d;
  logic                          underrun_q, underrun_d;
  logic signed [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
  logic signed [SAMPLE_BITS-1:0] hold_r_q, hold_r_d;
  logic                          tick, fall_evt, load_evt, accept;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    fall_evt  = tick && bclk_q;
    load_evt  = fall_evt && (slot_q == 5'd0);
    accept    = s_if.sample_valid && !full_q;

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    bclk_d    = bclk_q ^ tick;
    slot_d    = fall_evt ? slot_q + 5'd1 : slot_q;

    // Load happens entering slot 1, giving the one-BCLK I2S data delay.
    shift_d = shift_q;
    if (load_evt)
      shift_d = full_q ? {hold_l_q, hold_r_q} : '0;
    else if (fall_evt)
      shift_d = {shift_q[FRAME_W-2:0], 1'b0};

    underrun_d = load_evt && !full_q;
    // A pair accepted in the load cycle was not visible to that load; it waits.
    full_d   = accept || (full_q && !load_evt);
    hold_l_d = accept ? s_if.left_in  : hold_l_q;
    hold_r_d = accept ? s_if.right_in : hold_r_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      slot_q     <= 5'd0;
      shift_q    <= '0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      slot_q     <= slot_d;
      shift_q    <= shift_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  // Holding data is qualified by full_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end

  assign bclk              = bclk_q;
  assign lrclk             = slot_q[4];
  assign sdata             = shift_q[FRAME_W-1];
  assign underrun          = underrun_q;
  assign s_if.sample_ready = !full_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: decodes the I2S stream at BCLK rises and
// compares it against a frame-level model of buffering and frame timing.
module tb_i2s_tx;
  localparam int D = 2;

  logic clk, rst_n;
  logic bclk, lrclk, sdata, underrun;

  i2s_tx_if bus ();

  i2s_tx #(.CLK_DIV(D), .SAMPLE_BITS(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_if     (bus.slave),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int          n_checks, n_fail;
  int          cyc, nrise, nfall;
  bit          full_m, acc_flag, prev_bclk;
  logic [15:0] hl_m, hr_m;
  logic [31:0] exp_frames[$];
  logic [31:0] word, lrw;

  function automatic bit is_load(int c);
    return (c >= 2*D) && (((c - 2*D) % (64*D)) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic reset_model();
    cyc = 0; nrise = 0; nfall = 0; full_m = 0; acc_flag = 0;
    prev_bclk = 0; word = '0; lrw = '0;
    exp_frames.delete();
  endtask

  task automatic check_rise_count();
    chk("rise_count", nrise, (cyc >= D) ? ((cyc - D) / (2*D) + 1) : 0);
  endtask

  task automatic step();
    bit ld, expu;
    @(posedge clk);
    cyc++;
    ld       = is_load(cyc);
    expu     = ld && !full_m;
    acc_flag = bus.sample_valid && !full_m;
    if (ld) exp_frames.push_back(full_m ? {hl_m, hr_m} : 32'h0);
    if (acc_flag) begin
      hl_m = bus.left_in;
      hr_m = bus.right_in;
    end
    full_m = acc_flag || (full_m && !ld);
    #1;
    chk("underrun", underrun, expu);
    chk("sample_ready", bus.sample_ready, !full_m);
    if (bclk === 1'b1 && !prev_bclk) begin
      chk("rise_time", cyc, D + 2*D*nrise);
      if (nrise == 0) chk("slot0_idle", sdata, 1'b0);
      else begin
        word = {word[30:0], sdata};
        lrw  = {lrw[30:0], lrclk};
        if (nrise % 32 == 0) begin
          n_checks++;
          assert (exp_frames.size() > 0) else begin
            n_fail++;
            $error("FAIL frame_avail: observed none expected a queued frame");
          end
          if (exp_frames.size() > 0) chk("frame_data", word, exp_frames.pop_front());
          chk("lrclk_pattern", lrw, 32'h0001_FFFE);
        end
      end
      nrise++;
    end else if (bclk === 1'b0 && prev_bclk) begin
      chk("fall_time", cyc, 2*D*(nfall + 1));
      nfall++;
    end
    prev_bclk = (bclk === 1'b1);
  endtask

  task automatic wait_cycles(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    bit done;
    done = 0;
    bus.left_in = l; bus.right_in = r; bus.sample_valid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (acc_flag) done = 1;
    end
    bus.sample_valid = 1'b0;
    n_checks++;
    assert (done) else begin
      n_fail++;
      $error("FAIL send_timeout: observed no accept expected accept within 400 cycles");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_bclk", bclk, 1'b0);
    chk("rst_lrclk", lrclk, 1'b0);
    chk("rst_sdata", sdata, 1'b0);
    chk("rst_ready", bus.sample_ready, 1'b1);
    chk("rst_underrun", underrun, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    clk = 0; rst_n = 1'b1;
    bus.sample_valid = 1'b0; bus.left_in = '0; bus.right_in = '0;
    hl_m = '0; hr_m = '0;
    reset_model();
    #3;
    do_reset();

    // Pair offered before the first load, then an upstream stall.
    send_pair(16'hA5C3, 16'h7F01);
    wait_cycles(2*D + 64*D*2 + 20);

    // Continuous stream of incrementing pairs.
    for (int n = 1; n <= 8; n++) send_pair(16'(n), ~16'(n));
    send_pair(16'h8000, 16'hFFFF);

    // Random pairs with random gaps.
    for (int k = 0; k < 6; k++) begin
      wait_cycles($urandom_range(0, 200));
      send_pair(16'($urandom), 16'($urandom));
    end
    wait_cycles(300);

    // Valid rises exactly in a load cycle with holding empty.
    for (int i = 0; i < 200 && !is_load(cyc + 1); i++) step();
    bus.left_in = 16'h1357; bus.right_in = 16'h2468; bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    wait_cycles(300);

    // Mid-frame reset with a pair sitting in holding.
    send_pair(16'hDEAD, 16'hBEEF);
    for (int i = 0; i < 400 && (nrise % 32 != 21); i++) step();
    check_rise_count();
    do_reset();
    wait_cycles(2*D + 64*D*2 + 20);
    check_rise_count();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
